// File: rtl/filter_glb_pkg.sv
// Shared types and constants for the filter global-buffer sequencer.
package filter_glb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SERVE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int PASS_WIDTH    = 8;
  localparam int OUT_BUF_DEPTH = 2;
  localparam int LANES         = 4;
  localparam int LANE_SHIFT    = $clog2(LANES);

endpackage

// File: rtl/filter_out_buf.sv
// Small synchronous FIFO holding port-B read data until the PE array takes it.
module filter_out_buf
  import filter_glb_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = OUT_BUF_DEPTH,
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [OCC_W-1:0]      occ
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic                             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so pe_data reads 0 until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

endmodule

// File: rtl/filter_glb_ctrl.sv
// Filter GLB sequencer: loads packed words into the buffer via port A, then
// streams weights out of port B to the PE array for a number of passes.
module filter_glb_ctrl
  import filter_glb_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_WIDTH = 64,
  parameter  int MEM_DEPTH  = 16,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_num_elems,
  input  logic [PASS_WIDTH-1:0] cfg_num_passes,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  glb_we_a,
  output logic                  glb_re_a,
  output logic [ADDR_WIDTH-1:0] glb_addr_a,
  output logic [FIFO_WIDTH-1:0] glb_wdata_a,
  output logic                  glb_we_b,
  output logic                  glb_re_b,
  output logic [ADDR_WIDTH-1:0] glb_addr_b,
  input  logic [DATA_WIDTH-1:0] glb_rdata_b,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic                  pe_valid,
  input  logic                  pe_ready
);

  localparam int OCC_W = $clog2(OUT_BUF_DEPTH + 1);
  localparam int CNT_W = ADDR_WIDTH + 1;

  state_t                state, nxt;
  logic [CNT_W-1:0]      n_q, n_in, nwords, wcnt;
  logic [PASS_WIDTH-1:0] p_q, p_in, pass_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_pend;
  logic [OCC_W-1:0]      occ;
  logic                  buf_empty, hs, credit_ok, last_elem, last_pass;

  assign n_in      = (cfg_num_elems > CNT_W'(MEM_DEPTH)) ? CNT_W'(MEM_DEPTH) : cfg_num_elems;
  assign p_in      = (cfg_num_passes == '0) ? PASS_WIDTH'(1) : cfg_num_passes;
  assign nwords    = (n_q + CNT_W'(LANES - 1)) >> LANE_SHIFT;
  assign hs        = pe_valid && pe_ready;
  // Buffer slots not yet spoken for by stored data or an outstanding read.
  assign credit_ok = ({1'b0, occ} + (OCC_W + 1)'(rd_pend)) < (OCC_W + 1)'(OUT_BUF_DEPTH);
  assign last_elem = ({1'b0, rd_addr} == n_q - 1'b1);
  assign last_pass = (pass_cnt == p_q - 1'b1);

  assign busy        = (state == S_LOAD) || (state == S_SERVE) || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  assign glb_re_a    = 1'b0;
  assign glb_we_b    = 1'b0;
  assign glb_we_a    = fifo_rd_en;
  assign glb_wdata_a = fifo_rd_en ? fifo_dout : '0;
  assign glb_addr_a  = ADDR_WIDTH'({wcnt, {LANE_SHIFT{1'b0}}});
  assign glb_addr_b  = rd_addr;
  assign pe_valid    = !buf_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = state;
    fifo_rd_en = 1'b0;
    glb_re_b   = 1'b0;
    unique case (state)
      // An empty job skips straight to the drain check so busy still spans
      // one cycle and done lands two cycles after start.
      S_IDLE:  if (start) nxt = (n_in == '0) ? S_DRAIN : S_LOAD;
      S_LOAD: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_rd_en && (wcnt == nwords - 1'b1)) nxt = S_SERVE;
      end
      S_SERVE: begin
        glb_re_b = credit_ok || hs;
        if (glb_re_b && last_elem && last_pass) nxt = S_DRAIN;
      end
      // Look ahead one cycle so done follows the final handshake directly.
      S_DRAIN: if (!rd_pend && ((occ == '0) || ((occ == OCC_W'(1)) && hs))) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      p_q      <= '0;
      wcnt     <= '0;
      rd_addr  <= '0;
      pass_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= glb_re_b;
      if (state == S_IDLE && start) begin
        n_q      <= n_in;
        p_q      <= p_in;
        wcnt     <= '0;
        rd_addr  <= '0;
        pass_cnt <= '0;
      end
      if (fifo_rd_en) wcnt <= wcnt + 1'b1;
      if (glb_re_b) begin
        if (last_elem) begin
          rd_addr  <= '0;
          pass_cnt <= pass_cnt + 1'b1;
        end else begin
          rd_addr  <= rd_addr + 1'b1;
        end
      end
    end
  end

  filter_out_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (OUT_BUF_DEPTH)
  ) u_out_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (rd_pend),
    .din  (glb_rdata_b),
    .pop  (hs),
    .dout (pe_data),
    .empty(buf_empty),
    .occ  (occ)
  );

endmodule

// File: tb/tb_filter_glb_ctrl.sv
// Scoreboard bench for filter_glb_ctrl with FIFO and GLB behavioural models.
module tb_filter_glb_ctrl;
  localparam int DW = 16, FW = 64, MD = 16, AW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   cfg_num_elems = '0;
  logic [7:0]    cfg_num_passes = '0;
  logic          busy, done, fifo_empty, fifo_rd_en;
  logic [FW-1:0] fifo_dout, glb_wdata_a;
  logic          glb_we_a, glb_re_a, glb_we_b, glb_re_b;
  logic [AW-1:0] glb_addr_a, glb_addr_b;
  logic [DW-1:0] glb_rdata_b, pe_data;
  logic          pe_valid, pe_ready;

  filter_glb_ctrl #(.DATA_WIDTH(DW), .FIFO_WIDTH(FW), .MEM_DEPTH(MD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_elems(cfg_num_elems),
    .cfg_num_passes(cfg_num_passes), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .glb_we_a(glb_we_a), .glb_re_a(glb_re_a), .glb_addr_a(glb_addr_a),
    .glb_wdata_a(glb_wdata_a), .glb_we_b(glb_we_b), .glb_re_b(glb_re_b),
    .glb_addr_b(glb_addr_b), .glb_rdata_b(glb_rdata_b), .pe_data(pe_data),
    .pe_valid(pe_valid), .pe_ready(pe_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FWFT input FIFO model
  logic [FW-1:0] fmem [0:31];
  int fhead = 0, ftail = 0;
  assign fifo_empty = (fhead == ftail);
  assign fifo_dout  = fmem[fhead[4:0]];
  always @(posedge clk) if (fifo_rd_en) fhead <= fhead + 1;

  task automatic fifo_push(input logic [FW-1:0] w);
    fmem[ftail[4:0]] = w;
    ftail = ftail + 1;
  endtask

  // GLB model: wide write on A, 1-cycle latency narrow read on B
  logic [DW-1:0] gmem [0:MD-1];
  always @(posedge clk) begin
    if (glb_we_a)
      for (int i = 0; i < 4; i++) gmem[int'(glb_addr_a) + i] <= glb_wdata_a[16*i +: 16];
    if (glb_re_b) glb_rdata_b <= gmem[glb_addr_b];
  end

  int rdy_mode = 0;
  initial begin
    pe_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      pe_ready = (rdy_mode == 0) ? 1'b1 : cyc[0];
    end
  end

  function automatic logic [FW-1:0] mk_word(input int base, input int k);
    logic [FW-1:0] w;
    for (int l = 0; l < 4; l++) w[16*l +: 16] = 16'(base + 4*k + l + 1);
    return w;
  endfunction

  // Scoreboard queues and monitor state
  logic [DW-1:0] exp_pe [$];
  logic [AW-1:0] exp_wa [$];
  logic [FW-1:0] exp_wd [$];
  int   rd_budget = 0, hs_cnt = 0, first_hs = 0, last_hs = 0;
  int   m_occ = 0, m_infl = 0;
  bit   hold_v = 0, mhs;
  logic [DW-1:0] hold_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_occ = 0; m_infl = 0; hold_v = 0;
    end else begin
      mhs = pe_valid && pe_ready;
      chk("tieoffs", {glb_re_a, glb_we_b}, 2'b00);
      chk("pe_valid_latency", pe_valid, m_occ != 0);
      if (hold_v) chk("pe_hold", {pe_valid, pe_data}, {1'b1, hold_d});
      if (glb_we_a) begin
        chk("we_a_while_empty", fifo_empty, 1'b0);
        chk("we_a_expected", exp_wa.size() != 0, 1'b1);
        if (exp_wa.size() != 0) begin
          chk("addr_a", glb_addr_a, exp_wa.pop_front());
          chk("wdata_a", glb_wdata_a, exp_wd.pop_front());
        end
      end
      if (glb_re_b) begin
        chk("re_b_credit", (m_occ + m_infl < 2) || mhs, 1'b1);
        rd_budget--;
        chk("re_b_budget", rd_budget >= 0, 1'b1);
      end
      if (mhs) begin
        chk("pe_expected", exp_pe.size() != 0, 1'b1);
        if (exp_pe.size() != 0) chk("pe_data", pe_data, exp_pe.pop_front());
        if (hs_cnt == 0) first_hs = cyc;
        hs_cnt++;
        last_hs = cyc;
      end
      m_occ  = m_occ + m_infl - (mhs ? 1 : 0);
      m_infl = glb_re_b ? 1 : 0;
      hold_v = pe_valid && !pe_ready;
      hold_d = pe_data;
    end
  end

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {busy, done, fifo_rd_en, glb_we_a, glb_re_a, glb_we_b, glb_re_b, pe_valid}, 8'h0);
    chk({name, "_addr_data"}, {glb_addr_a, glb_addr_b, pe_data}, 24'h0);
    chk({name, "_wdata"}, glb_wdata_a, 64'h0);
  endtask

  task automatic queue_job(input int n, input int p, input int base);
    int nc, pc;
    nc = (n > MD) ? MD : n;
    pc = (p == 0) ? 1 : p;
    for (int ps = 0; ps < pc; ps++)
      for (int i = 0; i < nc; i++) exp_pe.push_back(16'(base + i + 1));
    for (int k = 0; k < (nc + 3) / 4; k++) begin
      exp_wa.push_back(AW'(4*k));
      exp_wd.push_back(mk_word(base, k));
    end
    rd_budget += nc * pc;
  endtask

  task automatic run_job(input int n, input int p, input int base, input bit gap,
                         input int rdy, input bit poke);
    int nc, pc, nw, t;
    bit got;
    nc = (n > MD) ? MD : n;
    pc = (p == 0) ? 1 : p;
    nw = (nc + 3) / 4;
    rdy_mode = rdy;
    hs_cnt = 0;
    queue_job(n, p, base);
    for (int k = 0; k < nw; k++) if (!gap || k == 0) fifo_push(mk_word(base, k));
    cfg_num_elems = (AW+1)'(n);
    cfg_num_passes = 8'(p);
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
    if (gap) begin
      repeat (4) @(posedge clk);
      #1;
      for (int k = 1; k < nw; k++) fifo_push(mk_word(base, k));
    end
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
      if (poke && k == 2) begin start = 1'b1; cfg_num_elems = 5'd2; end
      if (poke && k == 3) begin start = 1'b0; cfg_num_elems = (AW+1)'(n); end
    end
    chk("done_seen", got, 1'b1);
    if (got) begin
      if (nc == 0) chk("done_time_n0", cyc, t + 2);
      else         chk("done_after_last_hs", cyc, last_hs + 1);
      chk("busy_at_done", busy, 1'b0);
      chk("pe_left_over", exp_pe.size(), 0);
      chk("wa_left_over", exp_wa.size(), 0);
      if (rdy == 0 && nc > 0) chk("no_bubbles", last_hs - first_hs, nc * pc - 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(8, 1, 0,      0, 0, 0);  // weights 1..8 single pass
    run_job(6, 3, 16'h20, 0, 0, 0);  // three passes, wrap without gap
    run_job(8, 1, 16'h40, 0, 1, 1);  // alternating ready, start poked while busy
    run_job(8, 2, 16'h60, 1, 0, 0);  // FIFO gap during load
    run_job(0, 5, 16'h80, 0, 0, 0);  // empty job

    // Reset mid-SERVE then a fresh job must not see stale data
    rdy_mode = 0;
    hs_cnt = 0;
    queue_job(8, 4, 16'h100);
    fifo_push(mk_word(16'h100, 0));
    fifo_push(mk_word(16'h100, 1));
    cfg_num_elems = 5'd8;
    cfg_num_passes = 8'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    exp_pe.delete();
    exp_wa.delete();
    exp_wd.delete();
    rd_budget = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(4, 1, 16'h200, 0, 0, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
